// File: rtl/fpga_reset_seq.sv
// ----------------------------------------------------------------------------
// fpga_reset_seq
//
// Reset and clock bring-up sequencer sitting in front of the DCM. It holds the
// DCM in reset for a fixed interval, waits for LOCKED, lets lock settle, and
// only then releases the active-high core reset. A debounced front-panel
// button press or a loss of lock re-runs the whole sequence.
//
// Build option:
//   LOCK_TIMEOUT_EN  when defined, WAITLOCK gives up after LOCK_TIMEOUT cycles
//                    and retries via DCMRST. When undefined, WAITLOCK waits
//                    forever and LOCK_TIMEOUT has no effect.
//
// Ports:
//   clk          buffered board clock
//   reset_n      asynchronous active-low reset
//   button       raw, asynchronous, active-high reset button
//   dcm_locked   raw DCM LOCKED, asynchronous
//   dcm_reset    DCM RST, active-high (registered)
//   sys_reset    core reset, active-high (registered)
//   ready        high only while in RUN (registered)
//   retry_count  saturating count of restarts since reset_n (registered)
//   state_dbg    current FSM state: 0=DCMRST 1=WAITLOCK 2=SETTLE 3=RUN
// ----------------------------------------------------------------------------
module fpga_reset_seq #(
  parameter int unsigned DCM_RST_CYCLES  = 16,
  parameter int unsigned SETTLE_CYCLES   = 1024,
  parameter int unsigned LOCK_TIMEOUT    = 65536,
  parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       button,
  input  logic       dcm_locked,
  output logic       dcm_reset,
  output logic       sys_reset,
  output logic       ready,
  output logic [3:0] retry_count,
  output logic [1:0] state_dbg
);

  typedef enum logic [1:0] {
    S_DCMRST   = 2'd0,
    S_WAITLOCK = 2'd1,
    S_SETTLE   = 2'd2,
    S_RUN      = 2'd3
  } state_t;

  localparam logic [19:0] DCM_RST_LAST  = 20'(DCM_RST_CYCLES - 1);
  localparam logic [19:0] SETTLE_LAST   = 20'(SETTLE_CYCLES - 1);
  localparam logic [19:0] TIMEOUT_LAST  = 20'(LOCK_TIMEOUT - 1);
  localparam logic [19:0] DEBOUNCE_LAST = 20'(DEBOUNCE_CYCLES - 1);

`ifdef LOCK_TIMEOUT_EN
  localparam bit TIMEOUT_EN = 1'b1;
`else
  localparam bit TIMEOUT_EN = 1'b0;
`endif

  // --------------------------------------------------------------------------
  // Two-flop synchronisers for the asynchronous inputs.
  // --------------------------------------------------------------------------
  logic lock_s1, locked_s;
  logic btn_s1,  button_s;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      lock_s1  <= 1'b0;
      locked_s <= 1'b0;
      btn_s1   <= 1'b0;
      button_s <= 1'b0;
    end else begin
      lock_s1  <= dcm_locked;
      locked_s <= lock_s1;
      btn_s1   <= button;
      button_s <= btn_s1;
    end
  end

  // --------------------------------------------------------------------------
  // Button debouncer. The counter runs only while the synchronised button
  // disagrees with the accepted level; any cycle of agreement (a bounce back)
  // clears it. A new level is accepted after DEBOUNCE_CYCLES consecutive
  // disagreeing cycles. A press is a rising edge of the accepted level.
  // --------------------------------------------------------------------------
  logic [19:0] db_cnt;
  logic        db_level;
  logic        db_level_q;
  logic        press;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      db_cnt     <= '0;
      db_level   <= 1'b0;
      db_level_q <= 1'b0;
    end else begin
      db_level_q <= db_level;
      if (button_s == db_level) begin
        db_cnt <= '0;
      end else if (db_cnt == DEBOUNCE_LAST) begin
        db_level <= button_s;
        db_cnt   <= '0;
      end else if (db_cnt != '1) begin
        db_cnt <= db_cnt + 20'd1;
      end
    end
  end

  assign press = db_level & ~db_level_q;

  // --------------------------------------------------------------------------
  // Sequencer FSM with one shared state counter.
  // --------------------------------------------------------------------------
  state_t      state, state_nx;
  logic [19:0] count;
  logic        armed;
  logic        cnt_clr;
  logic        retry_inc;

  assign state_dbg = state;

  always_comb begin
    state_nx  = state;
    cnt_clr   = 1'b0;
    retry_inc = 1'b0;
    if (!armed) begin
      // First edge after reset release counts as the DCMRST entry edge, so
      // the initial DCM reset pulse is as long as every retry pulse.
      state_nx = state;
    end else if (press) begin
      // A press beats every other transition and restarts the DCM pulse
      // even if already in DCMRST.
      state_nx = S_DCMRST;
      cnt_clr  = 1'b1;
    end else begin
      case (state)
        S_DCMRST: begin
          if (count == DCM_RST_LAST) state_nx = S_WAITLOCK;
        end
        S_WAITLOCK: begin
          if (locked_s) begin
            state_nx = S_SETTLE;
          end else if (TIMEOUT_EN && (count == TIMEOUT_LAST)) begin
            state_nx  = S_DCMRST;
            retry_inc = 1'b1;
          end
        end
        S_SETTLE: begin
          if (!locked_s) begin
            state_nx  = S_DCMRST;
            retry_inc = 1'b1;
          end else if (count == SETTLE_LAST) begin
            state_nx = S_RUN;
          end
        end
        S_RUN: begin
          if (!locked_s) begin
            state_nx  = S_DCMRST;
            retry_inc = 1'b1;
          end
        end
        default: state_nx = S_DCMRST;
      endcase
    end
  end

  // Outputs are registered from the next state so they change on the same
  // edge as the state transition.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= S_DCMRST;
      count       <= '0;
      armed       <= 1'b0;
      retry_count <= 4'd0;
      dcm_reset   <= 1'b1;
      sys_reset   <= 1'b1;
      ready       <= 1'b0;
    end else begin
      armed <= 1'b1;
      state <= state_nx;
      if (!armed || cnt_clr || (state_nx != state)) begin
        count <= '0;
      end else if (count != '1) begin
        count <= count + 20'd1;
      end
      if (retry_inc && (retry_count != 4'hF)) begin
        retry_count <= retry_count + 4'd1;
      end
      dcm_reset <= (state_nx == S_DCMRST);
      sys_reset <= (state_nx != S_RUN);
      ready     <= (state_nx == S_RUN);
    end
  end

endmodule

// File: tb/tb_fpga_reset_seq.sv
// ----------------------------------------------------------------------------
// tb_fpga_reset_seq
//
// Bench for fpga_reset_seq with DCM_RST_CYCLES=4, SETTLE_CYCLES=8,
// LOCK_TIMEOUT=32, DEBOUNCE_CYCLES=4. Edges are numbered from the first
// rising clk edge after reset_n release (edge 0). Expected output vectors
// {dcm_reset, sys_reset, ready, retry_count} are queued against an edge number
// and compared half a cycle after that edge.
// ----------------------------------------------------------------------------
module tb_fpga_reset_seq;

  logic       clk;
  logic       reset_n;
  logic       button;
  logic       dcm_locked;
  logic       dcm_reset;
  logic       sys_reset;
  logic       ready;
  logic [3:0] retry_count;
  logic [1:0] state_dbg;

  fpga_reset_seq #(
    .DCM_RST_CYCLES (4),
    .SETTLE_CYCLES  (8),
    .LOCK_TIMEOUT   (32),
    .DEBOUNCE_CYCLES(4)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .button     (button),
    .dcm_locked (dcm_locked),
    .dcm_reset  (dcm_reset),
    .sys_reset  (sys_reset),
    .ready      (ready),
    .retry_count(retry_count),
    .state_dbg  (state_dbg)
  );

  // ---------------- clock / reset / edge numbering ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int edge_n;
  initial edge_n = -1;
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) edge_n <= -1;
    else          edge_n <= edge_n + 1;
  end

  logic [6:0] obs;
  assign obs = {dcm_reset, sys_reset, ready, retry_count};

  // ---------------- checker ----------------
  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // ---------------- scoreboard ----------------
  logic [6:0] exp_q[$];
  int         exp_edge_q[$];
  string      exp_tag_q[$];

  task automatic expect_at(input int e, input string tag, input logic dr,
                           input logic sr, input logic rdy, input logic [3:0] rc);
    exp_edge_q.push_back(e);
    exp_q.push_back({dr, sr, rdy, rc});
    exp_tag_q.push_back(tag);
  endtask

  int         mon_e;
  logic [6:0] mon_v;
  string      mon_t;
  always @(negedge clk) begin
    while (exp_edge_q.size() > 0 && edge_n >= 0 && exp_edge_q[0] <= edge_n) begin
      mon_e = exp_edge_q.pop_front();
      mon_v = exp_q.pop_front();
      mon_t = exp_tag_q.pop_front();
      if (mon_e == edge_n)
        check($sformatf("%s@%0d", mon_t, mon_e), 32'(obs), 32'(mon_v));
      else
        check($sformatf("%s_missed_edge", mon_t), 32'(edge_n), 32'(mon_e));
    end
  end

  // ---------------- driver tasks ----------------
  // Returns just after the falling edge that follows edge n; inputs driven
  // here are sampled at edge n+1.
  task automatic wait_edge(input int n);
    int budget;
    budget = 0;
    while (edge_n != n && budget < 2000) begin
      @(negedge clk);
      budget++;
    end
    if (edge_n != n) check("wait_edge", 32'(edge_n), 32'(n));
  endtask

  task automatic drain();
    int budget;
    budget = 0;
    while (exp_q.size() > 0 && budget < 2000) begin
      @(negedge clk);
      budget++;
    end
    check("drain_empty", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic apply_reset();
    @(negedge clk);
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check("reset_vals", 32'(obs), 32'(7'b110_0000));
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  // ---------------- stimulus ----------------
  logic [10:0] bounce_pat;

  initial begin
    reset_n    = 1'b1;
    button     = 1'b0;
    dcm_locked = 1'b0;
    bounce_pat = 11'b111_0111_0111;

    // Lock never arrives.
    apply_reset();
`ifdef LOCK_TIMEOUT_EN
    expect_at(0,   "to_start",  1'b1, 1'b1, 1'b0, 4'd0);
    expect_at(35,  "to_wait",   1'b0, 1'b1, 1'b0, 4'd0);
    expect_at(36,  "to_retry1", 1'b1, 1'b1, 1'b0, 4'd1);
    expect_at(39,  "to_rst1",   1'b1, 1'b1, 1'b0, 4'd1);
    expect_at(40,  "to_wait1",  1'b0, 1'b1, 1'b0, 4'd1);
    expect_at(504, "to_retry14",1'b1, 1'b1, 1'b0, 4'd14);
    expect_at(540, "to_retry15",1'b1, 1'b1, 1'b0, 4'd15);
    expect_at(576, "to_sat16",  1'b1, 1'b1, 1'b0, 4'd15);
    expect_at(612, "to_sat17",  1'b1, 1'b1, 1'b0, 4'd15);
    wait_edge(613);
`else
    expect_at(0,   "nto_start", 1'b1, 1'b1, 1'b0, 4'd0);
    expect_at(4,   "nto_wait",  1'b0, 1'b1, 1'b0, 4'd0);
    expect_at(50,  "nto_50",    1'b0, 1'b1, 1'b0, 4'd0);
    expect_at(100, "nto_100",   1'b0, 1'b1, 1'b0, 4'd0);
    expect_at(150, "nto_150",   1'b0, 1'b1, 1'b0, 4'd0);
    expect_at(200, "nto_200",   1'b0, 1'b1, 1'b0, 4'd0);
    wait_edge(201);
`endif
    drain();

    // Nominal bring-up, lock sampled high at edge 10.
    apply_reset();
    expect_at(0,  "nom_e0",    1'b1, 1'b1, 1'b0, 4'd0);
    expect_at(3,  "nom_dcm_hi",1'b1, 1'b1, 1'b0, 4'd0);
    expect_at(4,  "nom_dcm_lo",1'b0, 1'b1, 1'b0, 4'd0);
    expect_at(19, "nom_pre",   1'b0, 1'b1, 1'b0, 4'd0);
    expect_at(20, "nom_run",   1'b0, 1'b0, 1'b1, 4'd0);
    wait_edge(9);
    dcm_locked = 1'b1;

    // Lock loss in RUN, drop sampled at edge 30.
    expect_at(31, "loss_pre",  1'b0, 1'b0, 1'b1, 4'd0);
    expect_at(32, "loss_rst",  1'b1, 1'b1, 1'b0, 4'd1);
    expect_at(35, "loss_dcm",  1'b1, 1'b1, 1'b0, 4'd1);
    expect_at(36, "loss_wait", 1'b0, 1'b1, 1'b0, 4'd1);
    wait_edge(29);
    dcm_locked = 1'b0;

    // Lock returns (sampled 40), then drops during SETTLE (sampled 45).
    expect_at(42, "sdrop_settle", 1'b0, 1'b1, 1'b0, 4'd1);
    expect_at(44, "sdrop_mid",    1'b0, 1'b1, 1'b0, 4'd1);
    expect_at(46, "sdrop_pre",    1'b0, 1'b1, 1'b0, 4'd1);
    expect_at(47, "sdrop_rst",    1'b1, 1'b1, 1'b0, 4'd2);
    wait_edge(39);
    dcm_locked = 1'b1;
    wait_edge(44);
    dcm_locked = 1'b0;

    // Lock back (sampled 50): WAITLOCK at 51, SETTLE at 52, RUN at 60.
    expect_at(50, "rec_dcm",  1'b1, 1'b1, 1'b0, 4'd2);
    expect_at(51, "rec_wait", 1'b0, 1'b1, 1'b0, 4'd2);
    expect_at(59, "rec_pre",  1'b0, 1'b1, 1'b0, 4'd2);
    expect_at(60, "rec_run",  1'b0, 1'b0, 1'b1, 4'd2);
    wait_edge(49);
    dcm_locked = 1'b1;

    // Bouncing button: 3-cycle pulses, 1-cycle gaps, no restart.
    expect_at(72, "bounce_a", 1'b0, 1'b0, 1'b1, 4'd2);
    expect_at(78, "bounce_b", 1'b0, 1'b0, 1'b1, 4'd2);
    expect_at(85, "bounce_c", 1'b0, 1'b0, 1'b1, 4'd2);
    wait_edge(64);
    for (int i = 0; i < 11; i++) begin
      button = bounce_pat[i];
      @(negedge clk);
    end
    button = 1'b0;

    // Clean press sampled high 90..95: DCMRST at 96, full sequence again.
    expect_at(95,  "press_pre",  1'b0, 1'b0, 1'b1, 4'd2);
    expect_at(96,  "press_rst",  1'b1, 1'b1, 1'b0, 4'd2);
    expect_at(99,  "press_dcm",  1'b1, 1'b1, 1'b0, 4'd2);
    expect_at(100, "press_wait", 1'b0, 1'b1, 1'b0, 4'd2);
    expect_at(108, "press_set",  1'b0, 1'b1, 1'b0, 4'd2);
    expect_at(109, "press_run",  1'b0, 1'b0, 1'b1, 4'd2);
    wait_edge(89);
    button = 1'b1;
    wait_edge(95);
    button = 1'b0;

    // Enter SETTLE with retry_count=3, then async reset mid-SETTLE.
    expect_at(116, "pre6_run",  1'b0, 1'b0, 1'b1, 4'd2);
    expect_at(117, "pre6_rst",  1'b1, 1'b1, 1'b0, 4'd3);
    expect_at(121, "pre6_wait", 1'b0, 1'b1, 1'b0, 4'd3);
    expect_at(123, "pre6_set",  1'b0, 1'b1, 1'b0, 4'd3);
    wait_edge(114);
    dcm_locked = 1'b0;
    wait_edge(117);
    dcm_locked = 1'b1;
    wait_edge(123);
    drain();
    @(posedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    check("async_rst_now", 32'(obs), 32'(7'b110_0000));
    #4;
    reset_n = 1'b1;
    // Lock is already high: locked_s after edge 1, SETTLE at 5, RUN at 13.
    expect_at(0,  "ar_e0",   1'b1, 1'b1, 1'b0, 4'd0);
    expect_at(3,  "ar_dcm",  1'b1, 1'b1, 1'b0, 4'd0);
    expect_at(4,  "ar_wait", 1'b0, 1'b1, 1'b0, 4'd0);
    expect_at(12, "ar_pre",  1'b0, 1'b1, 1'b0, 4'd0);
    expect_at(13, "ar_run",  1'b0, 1'b0, 1'b1, 4'd0);
    wait_edge(14);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
